alu_datapath: RTL and testbench

ALU_DATAPATH -- requirements
Module: alu_datapath

---
 rtl/alu_datapath_pkg.sv | 46 ++++
 rtl/alu_datapath_divider.sv | 68 ++++++
 rtl/alu_datapath.sv | 147 ++++++++++++++
 tb/tb_alu_datapath.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_datapath_pkg.sv
// Shared definitions for the ALU datapath: operation encoding, bus-source encoding
// and the default data width. Optional divider is enabled by ALU_DATAPATH_DIV_EN.
package alu_datapath_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [2:0] {
        OP_NONE = 3'd0,
        OP_ADD  = 3'd1,
        OP_SUB  = 3'd2,
        OP_MUL  = 3'd3,
        OP_DIV  = 3'd4
    } alu_op_e;

    typedef enum logic [2:0] {
        SRC_NONE = 3'd0,
        SRC_R1   = 3'd1,
        SRC_R2   = 3'd2,
        SRC_Z    = 3'd3,
        SRC_EXT  = 3'd4
    } bus_src_e;

    // Highest-priority operation wins when the control unit raises several selects.
    function automatic alu_op_e decode_op(input logic sel_add, input logic sel_sub,
                                          input logic sel_mul, input logic sel_div);
        if (sel_div)      return OP_DIV;
        else if (sel_mul) return OP_MUL;
        else if (sel_sub) return OP_SUB;
        else if (sel_add) return OP_ADD;
        else              return OP_NONE;
    endfunction

    function automatic bus_src_e select_src(input logic sel_r1, input logic sel_r2,
                                            input logic sel_z, input logic sel_ext);
        if (sel_r1)       return SRC_R1;
        else if (sel_r2)  return SRC_R2;
        else if (sel_z)   return SRC_Z;
        else if (sel_ext) return SRC_EXT;
        else              return SRC_NONE;
    endfunction

    function automatic logic multi_select(input logic [3:0] sel);
        return ((sel & (sel - 4'd1)) != 4'd0);
    endfunction

endpackage

// File: rtl/alu_datapath_divider.sv
// Iterative restoring divider: one quotient bit per cycle, WIDTH cycles per divide.
// finish is high during the last busy cycle, when quotient/div_zero hold the result.
module alu_divider
    import alu_datapath_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             finish,
    output logic [WIDTH-1:0] quotient,
    output logic             div_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] rem_reg;
    logic [WIDTH-1:0] dvd_reg;
    logic [WIDTH-1:0] dvs_reg;
    logic [CW-1:0]    count_reg;
    logic             busy_reg;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic             qbit;
    logic [WIDTH-1:0] rem_next;

    // A zero divisor always "fits", which yields the all-ones quotient for free.
    always_comb begin
        shifted  = {rem_reg, dvd_reg[WIDTH-1]};
        trial    = shifted - {1'b0, dvs_reg};
        qbit     = (shifted >= {1'b0, dvs_reg});
        rem_next = qbit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    end

    assign busy     = busy_reg;
    assign finish   = busy_reg && (count_reg == CW'(WIDTH - 1));
    assign quotient = {dvd_reg[WIDTH-2:0], qbit};
    assign div_zero = (dvs_reg == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_reg   <= '0;
            dvd_reg   <= '0;
            dvs_reg   <= '0;
            count_reg <= '0;
            busy_reg  <= 1'b0;
        end else if (start && !busy_reg) begin
            rem_reg   <= '0;
            dvd_reg   <= a;
            dvs_reg   <= b;
            count_reg <= '0;
            busy_reg  <= 1'b1;
        end else if (busy_reg) begin
            rem_reg   <= rem_next;
            dvd_reg   <= quotient;
            count_reg <= count_reg + CW'(1);
            if (finish) begin
                busy_reg <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_datapath.sv
// Bus-based register/ALU datapath driven by an external control unit.
// Define ALU_DATAPATH_DIV_EN to build the iterative divider; otherwise Div is illegal.
module alu_datapath
    import alu_datapath_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic             R1in,
    input  logic             R2in,
    input  logic             Yin,
    input  logic             Zin,
    input  logic             R1out,
    input  logic             R2out,
    input  logic             Zout,
    input  logic             Add,
    input  logic             Sub,
    input  logic             Mul,
    input  logic             Div,
    input  logic             SelectY,
    input  logic             ExtIn,
    input  logic [WIDTH-1:0] ExtData,
    output logic [WIDTH-1:0] Bus,
    output logic             Done,
    output logic             Busy,
    output logic             OpError,
    output logic             DivZero
);

    logic [WIDTH-1:0] r1_reg;
    logic [WIDTH-1:0] r2_reg;
    logic [WIDTH-1:0] y_reg;
    logic [WIDTH-1:0] z_reg;
    logic             done_reg;
    logic             operror_reg;

    bus_src_e         bus_src;
    alu_op_e          op;
    logic             multi;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] alu_result;
    logic             issue;

    logic             div_busy;
    logic             div_finish;
    logic [WIDTH-1:0] div_quotient;
    logic             z_load_alu;
    logic             op_illegal;

    assign bus_src   = select_src(R1out, R2out, Zout, ExtIn);
    assign op        = decode_op(Add, Sub, Mul, Div);
    assign multi     = multi_select({Add, Sub, Mul, Div});
    assign operand_a = SelectY ? y_reg : '0;
    assign issue     = Zin && !div_busy;

    always_comb begin
        Bus = '0;
        case (bus_src)
            SRC_R1:  Bus = r1_reg;
            SRC_R2:  Bus = r2_reg;
            SRC_Z:   Bus = z_reg;
            SRC_EXT: Bus = ExtData;
            default: Bus = '0;
        endcase
    end

    // OP_DIV only reaches this mux when the divider is not built, and then yields zero.
    always_comb begin
        alu_result = operand_a;
        case (op)
            OP_ADD:  alu_result = operand_a + Bus;
            OP_SUB:  alu_result = operand_a - Bus;
            OP_MUL:  alu_result = operand_a * Bus;
            OP_DIV:  alu_result = '0;
            default: alu_result = operand_a;
        endcase
    end

`ifdef ALU_DATAPATH_DIV_EN
    logic div_zero;
    logic divzero_reg;

    alu_divider #(
        .WIDTH(WIDTH)
    ) u_divider (
        .clk     (Clock),
        .rst_n   (Resetn),
        .start   (issue && (op == OP_DIV)),
        .a       (operand_a),
        .b       (Bus),
        .busy    (div_busy),
        .finish  (div_finish),
        .quotient(div_quotient),
        .div_zero(div_zero)
    );

    assign z_load_alu = issue && (op != OP_DIV);
    assign op_illegal = issue && multi;

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            divzero_reg <= 1'b0;
        end else if (div_finish && div_zero) begin
            divzero_reg <= 1'b1;
        end
    end

    assign DivZero = divzero_reg;
`else
    assign div_busy     = 1'b0;
    assign div_finish   = 1'b0;
    assign div_quotient = '0;
    assign z_load_alu   = issue;
    assign op_illegal   = issue && (multi || (op == OP_DIV));
    assign DivZero      = 1'b0;
`endif

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r1_reg      <= '0;
            r2_reg      <= '0;
            y_reg       <= '0;
            z_reg       <= '0;
            done_reg    <= 1'b0;
            operror_reg <= 1'b0;
        end else begin
            if (R1in) r1_reg <= Bus;
            if (R2in) r2_reg <= Bus;
            if (Yin)  y_reg  <= Bus;
            if (div_finish) begin
                z_reg <= div_quotient;
            end else if (z_load_alu) begin
                z_reg <= alu_result;
            end
            done_reg <= div_finish || z_load_alu;
            if (op_illegal) begin
                operror_reg <= 1'b1;
            end
        end
    end

    assign Done    = done_reg;
    assign Busy    = div_busy;
    assign OpError = operror_reg;

endmodule

// File: tb/tb_alu_datapath.sv
// Directed bench for alu_datapath: a behavioural model checked every cycle plus
// hand-computed literal expectations. Divider expectations follow ALU_DATAPATH_DIV_EN.
module tb_alu_datapath;

    localparam int W    = 8;
    localparam int MASK = 255;

    logic         Clock = 1'b0;
    logic         Resetn = 1'b0;
    logic         R1in, R2in, Yin, Zin, R1out, R2out, Zout;
    logic         Add, Sub, Mul, Div, SelectY, ExtIn;
    logic [W-1:0] ExtData;
    logic [W-1:0] Bus;
    logic         Done, Busy, OpError, DivZero;

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    alu_datapath #(.WIDTH(W)) dut (
        .Clock(Clock), .Resetn(Resetn),
        .R1in(R1in), .R2in(R2in), .Yin(Yin), .Zin(Zin),
        .R1out(R1out), .R2out(R2out), .Zout(Zout),
        .Add(Add), .Sub(Sub), .Mul(Mul), .Div(Div),
        .SelectY(SelectY), .ExtIn(ExtIn), .ExtData(ExtData),
        .Bus(Bus), .Done(Done), .Busy(Busy), .OpError(OpError), .DivZero(DivZero)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [W-1:0] m_r1, m_r2, m_y, m_z, m_q;
    logic         m_busy, m_done, m_operr, m_divzero, m_dz;
    int           m_left;

    function automatic logic [W-1:0] mbus();
        if (R1out)      return m_r1;
        else if (R2out) return m_r2;
        else if (Zout)  return m_z;
        else if (ExtIn) return ExtData;
        return '0;
    endfunction

    function automatic int ma();
        return SelectY ? int'(m_y) : 0;
    endfunction

    function automatic int nsel();
        return int'(Add) + int'(Sub) + int'(Mul) + int'(Div);
    endfunction

    always @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            m_r1 <= '0; m_r2 <= '0; m_y <= '0; m_z <= '0; m_q <= '0;
            m_busy <= 1'b0; m_done <= 1'b0; m_operr <= 1'b0; m_divzero <= 1'b0;
            m_dz <= 1'b0; m_left <= 0;
        end else begin
            if (R1in) m_r1 <= mbus();
            if (R2in) m_r2 <= mbus();
            if (Yin)  m_y  <= mbus();
            m_done <= 1'b0;
            if (m_busy) begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_busy <= 1'b0;
                    m_z    <= m_q;
                    m_done <= 1'b1;
                    if (m_dz) m_divzero <= 1'b1;
                end
            end else if (Zin) begin
                if (nsel() > 1) m_operr <= 1'b1;
                if (Div) begin
`ifdef ALU_DATAPATH_DIV_EN
                    m_busy <= 1'b1;
                    m_left <= W;
                    m_dz   <= (mbus() == 0);
                    m_q    <= (mbus() == 0) ? W'(MASK) : W'(ma() / int'(mbus()));
`else
                    m_z     <= '0;
                    m_operr <= 1'b1;
                    m_done  <= 1'b1;
`endif
                end else begin
                    m_done <= 1'b1;
                    if (Mul)      m_z <= W'((ma() * int'(mbus())) & MASK);
                    else if (Sub) m_z <= W'((ma() - int'(mbus())) & MASK);
                    else if (Add) m_z <= W'((ma() + int'(mbus())) & MASK);
                    else          m_z <= W'(ma());
                end
            end
        end
    end

    always @(negedge Clock) begin
        if (check_en) begin
            chk("bus", Bus, mbus());
            chk("done", Done, m_done);
            chk("busy", Busy, m_busy);
            chk("operror", OpError, m_operr);
            chk("divzero", DivZero, m_divzero);
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle();
        R1in = 0; R2in = 0; Yin = 0; Zin = 0; R1out = 0; R2out = 0; Zout = 0;
        Add = 0; Sub = 0; Mul = 0; Div = 0; SelectY = 0; ExtIn = 0; ExtData = '0;
    endtask

    task automatic cycle();
        @(posedge Clock);
        #1;
    endtask

    task automatic load_ext(input logic [W-1:0] v, input logic r1, input logic r2, input logic y);
        idle(); ExtIn = 1; ExtData = v; R1in = r1; R2in = r2; Yin = y;
        cycle();
        $display("txn: load %0h r1=%0d r2=%0d y=%0d", v, r1, r2, y);
    endtask

    task automatic read_z(input string name, input logic [W-1:0] exp);
        idle(); Zout = 1; #1;
        chk(name, Bus, exp);
        $display("txn: read Z for %s = %0h", name, Bus);
    endtask

    task automatic wait_not_busy(input string name);
        for (int i = 0; i < 20; i++) begin
            if (!Busy) break;
            idle();
            cycle();
        end
        chk(name, Busy, 1'b0);
    endtask

    int bcnt;
    int dcnt;

    initial begin
        idle();
        Resetn = 0;
        repeat (3) @(posedge Clock);
        #1;
        Resetn = 1;
        check_en = 1'b1;

        // reset state
        idle(); R1out = 1; #1; chk("reset_r1", Bus, 0);
        idle(); R2out = 1; #1; chk("reset_r2", Bus, 0);
        read_z("reset_z", 0);
        chk("reset_flags", {Busy, Done, OpError, DivZero}, 4'b0000);

        // R1 from external, Y from R1
        load_ext(8'd5, 1, 0, 0);
        idle(); R1out = 1; Yin = 1; cycle();
        idle(); R1out = 1; #1; chk("r1_load", Bus, 5);
        idle(); SelectY = 1; Zin = 1; cycle();      // Z <= A = Y
        chk("pass_a_done", Done, 1);
        read_z("y_via_z", 5);

        // 5 - 3
        load_ext(8'd3, 0, 1, 0);
        idle(); R2out = 1; SelectY = 1; Sub = 1; Zin = 1; cycle();
        chk("sub_done", Done, 1);
        read_z("sub_5_3", 2);
        cycle();
        chk("sub_done_pulse", Done, 0);

        // 3 - 5 wraps
        load_ext(8'd3, 0, 0, 1);
        idle(); ExtIn = 1; ExtData = 5; SelectY = 1; Sub = 1; Zin = 1; cycle();
        read_z("sub_wrap", 8'hFE);
        chk("operror_clean", OpError, 0);

        // Add+Mul collide: Mul wins and flags error
        load_ext(8'd4, 0, 0, 1);
        idle(); ExtIn = 1; ExtData = 3; SelectY = 1; Add = 1; Mul = 1; Zin = 1; cycle();
        read_z("mul_prio", 12);
        chk("operror_set", OpError, 1);

        // bus priority
        idle(); R1out = 1; R2out = 1; Zout = 1; ExtIn = 1; ExtData = 8'h77; #1;
        chk("prio_r1", Bus, 5);
        R1out = 0; #1; chk("prio_r2", Bus, 3);
        R2out = 0; #1; chk("prio_z", Bus, 12);
        Zout = 0;  #1; chk("prio_ext", Bus, 8'h77);
        ExtIn = 0; #1; chk("prio_none", Bus, 0);

        // 20 / 6
        load_ext(8'd20, 0, 0, 1);
        idle(); ExtIn = 1; ExtData = 6; SelectY = 1; Div = 1; Zin = 1; cycle();
        $display("txn: divide 20 by 6");
`ifdef ALU_DATAPATH_DIV_EN
        bcnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (!Busy) break;
            bcnt++;
            idle(); Zout = 1;
            if (i == 3) begin Zin = 1; SelectY = 1; Add = 1; end
            cycle();
        end
        chk("div_busy_cycles", bcnt, 8);
        chk("div_done", Done, 1);
        read_z("div_20_6", 3);
        cycle();
        chk("div_done_pulse", Done, 0);
        chk("divzero_clean", DivZero, 0);
`else
        chk("nodiv_busy", Busy, 0);
        chk("nodiv_done", Done, 1);
        chk("nodiv_operror", OpError, 1);
        read_z("nodiv_z", 0);
`endif

        // 7 / 0
        load_ext(8'd7, 0, 0, 1);
        idle(); ExtIn = 1; ExtData = 0; SelectY = 1; Div = 1; Zin = 1; cycle();
        $display("txn: divide 7 by 0");
        wait_not_busy("div0_timeout");
`ifdef ALU_DATAPATH_DIV_EN
        read_z("div0_z", 8'hFF);
        chk("div0_flag", DivZero, 1);
`else
        read_z("div0_z", 0);
        chk("div0_flag", DivZero, 0);
`endif

        // reset in the middle of a divide
        load_ext(8'd9, 1, 1, 1);
        idle(); ExtIn = 1; ExtData = 2; SelectY = 1; Div = 1; Zin = 1; cycle();
        idle(); cycle(); cycle();
        Resetn = 0; #1;
        chk("rst_flags", {Busy, Done, OpError, DivZero}, 4'b0000);
        R1out = 1; #1; chk("rst_r1", Bus, 0);
        R1out = 0; R2out = 1; #1; chk("rst_r2", Bus, 0);
        R2out = 0;
        Resetn = 1;
        read_z("rst_z", 0);
        $display("txn: reset mid-divide");
        dcnt = 0;
        for (int i = 0; i < 12; i++) begin
            idle(); cycle();
            dcnt += int'(Done);
        end
        chk("rst_no_done", dcnt, 0);
        idle(); SelectY = 1; Zin = 1; cycle();
        read_z("rst_y", 0);

        idle();
        cycle();
        check_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
